// File: rtl/pll_reset_ctrl_if.sv
// PLL supervisor signal bundle: the PLL lock/software-request inputs and the
// reset/status outputs.
// master: the supervisor (pll_reset_ctrl). slave: the PLL/system side.
interface pll_reset_ctrl_if;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       lock_fail;
  logic [7:0] relock_count;

  modport master (
    input  pll_locked,
    input  sw_rst_req,
    output pll_rst,
    output sys_rst_n,
    output ready,
    output lock_fail,
    output relock_count
  );

  modport slave (
    output pll_locked,
    output sw_rst_req,
    input  pll_rst,
    input  sys_rst_n,
    input  ready,
    input  lock_fail,
    input  relock_count
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset supervisor, clocked by the reference clock so it keeps running
// while the PLL output is dead.
// - Pulses pll_rst.
// - Waits for a stable, synchronized lock.
// - Holds sys_rst_n low until lock has been stable for LOCK_STABLE_CYCLES.
// - Drops sys_rst_n again whenever lock is lost.
// Optional macro PLL_WATCHDOG_EN adds a LOCK_TIMEOUT watchdog in WAIT_LOCK. On
// timeout the PLL is re-reset and lock_fail pulses for one cycle. Without the
// macro, WAIT_LOCK waits forever and lock_fail is tied low.
module pll_reset_ctrl #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 50000,
  parameter int unsigned CNT_W              = 17
) (
  input  logic               refclk,
  input  logic               rst_n,
  pll_reset_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    StResetPll,
    StWaitLock,
    StStabilize,
    StRun
  } state_e;

  localparam logic [CNT_W-1:0] RstLast    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast = CNT_W'(LOCK_STABLE_CYCLES - 1);

  // Largest terminal count of any state. The counter holds here rather than
  // wrapping, so a compare can never be skipped past.
  localparam int unsigned MaxRstStable = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                         PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned CntMax       = (MaxRstStable > LOCK_TIMEOUT) ?
                                         MaxRstStable : LOCK_TIMEOUT;
  localparam logic [CNT_W-1:0] CntLimit = CNT_W'(CntMax);

`ifdef PLL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
`endif

  logic             sync1_q;
  logic             locked_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             pll_rst_q;
  logic             sys_rst_n_q;
  logic             ready_q;
  logic [7:0]       relock_q;
`ifdef PLL_WATCHDOG_EN
  logic             lock_fail_q;
`endif

  // Two-flop synchronizer: pll_locked is asynchronous to refclk.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1_q  <= bus.pll_locked;
      locked_s <= sync1_q;
    end
  end

  assign cnt_inc = (cnt_q == CntLimit) ? cnt_q : cnt_q + CNT_W'(1);

  // Supervisor FSM with registered outputs; software reset overrides everything.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StResetPll;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      relock_q    <= '0;
`ifdef PLL_WATCHDOG_EN
      lock_fail_q <= 1'b0;
`endif
    end else begin
`ifdef PLL_WATCHDOG_EN
      lock_fail_q <= 1'b0;
`endif
      if (bus.sw_rst_req) begin
        state_q     <= StResetPll;
        cnt_q       <= '0;
        pll_rst_q   <= 1'b1;
        sys_rst_n_q <= 1'b0;
        ready_q     <= 1'b0;
      end else begin
        unique case (state_q)
          StResetPll: begin
            if (cnt_q == RstLast) begin
              state_q   <= StWaitLock;
              cnt_q     <= '0;
              pll_rst_q <= 1'b0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          StWaitLock: begin
            if (locked_s) begin
              state_q <= StStabilize;
              cnt_q   <= '0;
`ifdef PLL_WATCHDOG_EN
            end else if (cnt_q == TimeoutLast) begin
              state_q     <= StResetPll;
              cnt_q       <= '0;
              pll_rst_q   <= 1'b1;
              lock_fail_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
`else
            end else begin
              cnt_q <= '0;
            end
`endif
          end
          StStabilize: begin
            if (!locked_s) begin
              state_q <= StWaitLock;
              cnt_q   <= '0;
            end else if (cnt_q == StableLast) begin
              state_q     <= StRun;
              cnt_q       <= '0;
              sys_rst_n_q <= 1'b1;
              ready_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          StRun: begin
            if (!locked_s) begin
              state_q     <= StWaitLock;
              cnt_q       <= '0;
              sys_rst_n_q <= 1'b0;
              ready_q     <= 1'b0;
              if (relock_q != 8'hff) begin
                relock_q <= relock_q + 8'd1;
              end
            end
          end
          default: begin
            state_q     <= StResetPll;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.sys_rst_n    = sys_rst_n_q;
  assign bus.ready        = ready_q;
  assign bus.relock_count = relock_q;
`ifdef PLL_WATCHDOG_EN
  assign bus.lock_fail    = lock_fail_q;
`else
  assign bus.lock_fail    = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl.
// The reference model tracks lock as run lengths:
// - remaining PLL-reset cycles,
// - length of the current synchronized-lock streak,
// - consecutive unlocked cycles spent waiting.
// Each posedge pushes the expected outputs into a queue. A negedge monitor pops
// the queue and compares against the DUT.
module tb_pll_reset_ctrl;

  localparam int unsigned Prc = 4;
  localparam int unsigned Lsc = 8;
  localparam int unsigned Lt  = 32;
  localparam int unsigned Cw  = 17;
`ifdef PLL_WATCHDOG_EN
  localparam bit Wd = 1'b1;
`else
  localparam bit Wd = 1'b0;
`endif

  typedef struct packed {
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       lock_fail;
    logic [7:0] relock;
  } exp_t;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;

  pll_reset_ctrl_if bus ();

  pll_reset_ctrl #(
    .PLL_RST_CYCLES    (Prc),
    .LOCK_STABLE_CYCLES(Lsc),
    .LOCK_TIMEOUT      (Lt),
    .CNT_W             (Cw)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #10 refclk = ~refclk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Reference model state.
  bit   pipe[$];
  int   m_rst_left;
  int   m_streak;
  int   m_miss;
  int   m_relock;
  bit   m_ls;
  bit   m_fail;
  exp_t m_e;

  initial begin
    forever begin
      @(posedge refclk or negedge rst_n);
      if (!rst_n) begin
        pipe       = '{0, 0};
        m_rst_left = Prc;
        m_streak   = 0;
        m_miss     = 0;
        m_relock   = 0;
        exp_q.delete();
      end else begin
        m_ls = pipe.pop_front();
        pipe.push_back(bus.pll_locked);
        m_fail = 1'b0;
        if (bus.sw_rst_req) begin
          m_rst_left = Prc;
          m_streak   = 0;
          m_miss     = 0;
        end else if (m_rst_left > 0) begin
          m_rst_left--;
          m_streak = 0;
          m_miss   = 0;
        end else if (m_ls) begin
          if (m_streak <= Lsc) m_streak++;
          m_miss = 0;
        end else begin
          // Lock loss while released from reset counts as a relock event.
          if (m_streak > Lsc && m_relock < 255) m_relock++;
          if (m_streak > 0) begin
            // The cycle that notices the loss does not count toward the timeout.
            m_streak = 0;
            m_miss   = 0;
          end else begin
            m_miss++;
            if (Wd && m_miss == Lt) begin
              m_fail     = 1'b1;
              m_rst_left = Prc;
              m_miss     = 0;
            end
          end
        end
        m_e.pll_rst   = (m_rst_left > 0);
        m_e.sys_rst_n = (m_rst_left == 0) && (m_streak > Lsc);
        m_e.ready     = m_e.sys_rst_n;
        m_e.lock_fail = m_fail;
        m_e.relock    = 8'(m_relock);
        exp_q.push_back(m_e);
      end
    end
  end

  // Monitor: the DUT presents a fresh output set every cycle.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge refclk);
      if (!rst_n) begin
        check("reset pll_rst", 32'(bus.pll_rst), 1);
        check("reset sys_rst_n", 32'(bus.sys_rst_n), 0);
        check("reset relock_count", 32'(bus.relock_count), 0);
      end else if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pll_rst", 32'(bus.pll_rst), 32'(mon_e.pll_rst));
        check("sys_rst_n", 32'(bus.sys_rst_n), 32'(mon_e.sys_rst_n));
        check("ready", 32'(bus.ready), 32'(mon_e.ready));
        check("lock_fail", 32'(bus.lock_fail), 32'(mon_e.lock_fail));
        check("relock_count", 32'(bus.relock_count), 32'(mon_e.relock));
      end
    end
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.ready && n < budget);
    check("ready within budget", 32'(bus.ready), 1);
  endtask

  int n;
  int cnt;
  int lf_cnt;
  int pr_cnt;
  int exp_lf;
  int relock_before;

  initial begin
    bus.pll_locked = 1'b0;
    bus.sw_rst_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Power-up: pll_rst pulse width, then lock-to-release latency.
    cnt = bus.pll_rst ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.pll_rst) cnt++;
    end
    check("pll_rst cycles after release", cnt, Prc);
    bus.pll_locked = 1'b1;
    wait_ready(60, n);
    check("lock to ready latency", n, 2 + Lsc + 1);
    check("relock after power-up", 32'(bus.relock_count), 0);

    // Lock drop in RUN: 3-edge latency, relock count, re-release latency.
    bus.pll_locked = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.sys_rst_n && n < 10);
    check("drop to sys_rst_n low latency", n, 3);
    tick();
    tick();
    bus.pll_locked = 1'b1;
    wait_ready(60, n);
    check("relock to ready latency", n, 2 + Lsc + 1);
    check("relock_count after one loss", 32'(bus.relock_count), 1);

    // One-cycle glitch while stabilizing at count 5 restarts the count.
    bus.pll_locked = 1'b0;
    tick();
    tick();
    bus.pll_locked = 1'b1;
    repeat (6) tick();
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    wait_ready(60, n);
    check("ready after glitch latency", n, 2 + Lsc + 1);

    // Software reset in the same cycle that locked_s falls in RUN.
    relock_before  = bus.relock_count;
    bus.pll_locked = 1'b0;
    tick();
    tick();
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    cnt = 0;
    while (bus.pll_rst && cnt < 20) begin
      cnt++;
      tick();
    end
    check("pll_rst cycles after sw reset", cnt, Prc);
    check("relock unchanged by sw reset", 32'(bus.relock_count), 32'(relock_before));
    bus.pll_locked = 1'b1;
    wait_ready(60, n);

    // Lock held low: watchdog timeouts (or none without the watchdog).
    exp_lf = Wd ? (200 + 1) / (Lt + Prc) : 0;
    bus.pll_locked = 1'b0;
    lf_cnt = 0;
    pr_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.lock_fail) lf_cnt++;
      if (bus.pll_rst) pr_cnt++;
    end
    check("lock_fail pulses in 200 cycles", lf_cnt, exp_lf);
    check("pll_rst cycles in 200 cycles", pr_cnt, exp_lf * Prc);
    bus.pll_locked = 1'b1;
    wait_ready(200, n);

    // Randomized lock waveform with sporadic software resets.
    for (int seg = 0; seg < 60; seg++) begin
      bus.pll_locked = ($urandom_range(0, 2) != 0);
      cnt = $urandom_range(1, 45);
      for (int c = 0; c < cnt; c++) begin
        bus.sw_rst_req = ($urandom_range(0, 63) == 0);
        tick();
      end
      bus.sw_rst_req = 1'b0;
    end
    bus.pll_locked = 1'b1;
    wait_ready(200, n);

    // Saturation: 260 lock losses from RUN.
    for (int i = 0; i < 260; i++) begin
      bus.pll_locked = 1'b0;
      repeat (3) tick();
      bus.pll_locked = 1'b1;
      wait_ready(60, n);
    end
    check("relock_count saturated", 32'(bus.relock_count), 255);

    // Asynchronous reset in the middle of STABILIZE.
    bus.pll_locked = 1'b0;
    repeat (3) tick();
    bus.pll_locked = 1'b1;
    repeat (6) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset pll_rst", 32'(bus.pll_rst), 1);
    check("async reset sys_rst_n", 32'(bus.sys_rst_n), 0);
    check("async reset ready", 32'(bus.ready), 0);
    check("async reset relock_count", 32'(bus.relock_count), 0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_ready(60, n);
    check("release to ready with lock held", n, Prc + Lsc + 1);
    check("relock_count after reset", 32'(bus.relock_count), 0);

    tick();
    @(negedge refclk);
    #1;
    check("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion",
             n_checks);
    $fatal(1, "time limit");
  end

endmodule
